ifetch_router: RTL and testbench



---
 rtl/ifetch_router.sv | 144 ++++++++++++++
 tb/tb_ifetch_router.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_router.sv
// Instruction-fetch router: decodes each fetch to one of NrTargets targets and returns responses in grant order.
// Latency: request/grant are combinational; responses pass through combinationally, unmapped fetches answer one cycle after grant.
// Backpressure: no grant while MaxOutstanding fetches are pending; otherwise the grant follows the selected target.
module ifetch_router #(
  parameter int unsigned NrTargets      = 2,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                instr_req_i,
  input  logic [AddrWidth-1:0]                instr_addr_i,
  output logic                                instr_gnt_o,
  output logic                                instr_rvalid_o,
  output logic [DataWidth-1:0]                instr_rdata_o,
  output logic                                instr_err_o,
  input  logic [NrTargets-1:0][AddrWidth-1:0] cfg_addr_base_i,
  input  logic [NrTargets-1:0][AddrWidth-1:0] cfg_addr_mask_i,
  output logic [NrTargets-1:0]                tgt_req_o,
  output logic [AddrWidth-1:0]                tgt_addr_o,
  input  logic [NrTargets-1:0]                tgt_gnt_i,
  input  logic [NrTargets-1:0]                tgt_rvalid_i,
  input  logic [NrTargets-1:0][DataWidth-1:0] tgt_rdata_i,
  input  logic [NrTargets-1:0]                tgt_err_i,
  output logic                                proto_err_o
);

  localparam int unsigned IdWidth  = $clog2(NrTargets + 1);
  localparam int unsigned PtrWidth = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);
  // Target index NrTargets marks a fetch that hit no address window.
  localparam logic [IdWidth-1:0] UnmappedId = IdWidth'(NrTargets);

  logic [MaxOutstanding-1:0][IdWidth-1:0] fifo_q, fifo_d;
  logic [PtrWidth-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                proto_err_q, proto_err_d;

  logic [IdWidth-1:0] dec_id, head_id;
  logic full, empty, push, pop, stray;

  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    return (p == PtrWidth'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full        = (cnt_q == CntWidth'(MaxOutstanding));
  assign empty       = (cnt_q == '0);
  assign head_id     = fifo_q[rptr_q];
  assign tgt_addr_o  = instr_addr_i;
  assign proto_err_o = proto_err_q;

  // Address decode: walk downwards so the lowest matching target wins.
  always_comb begin
    dec_id = UnmappedId;
    for (int k = int'(NrTargets) - 1; k >= 0; k--) begin
      if ((instr_addr_i & cfg_addr_mask_i[k]) == cfg_addr_base_i[k]) dec_id = IdWidth'(k);
    end
  end

  // Request steering and grant; unmapped fetches are granted locally.
  always_comb begin
    tgt_req_o   = '0;
    instr_gnt_o = 1'b0;
    if (!full) begin
      if (dec_id == UnmappedId) begin
        instr_gnt_o = instr_req_i;
      end else begin
        for (int k = 0; k < int'(NrTargets); k++) begin
          if (dec_id == IdWidth'(k)) begin
            tgt_req_o[k] = instr_req_i;
            instr_gnt_o  = tgt_gnt_i[k];
          end
        end
      end
    end
  end

  assign push = instr_req_i & instr_gnt_o;

  // Response mux from the head-of-queue target; stray responses are flagged.
  always_comb begin
    instr_rvalid_o = 1'b0;
    instr_rdata_o  = '0;
    instr_err_o    = 1'b0;
    stray          = 1'b0;
    if (!empty) begin
      if (head_id == UnmappedId) begin
        instr_rvalid_o = 1'b1;
        instr_err_o    = 1'b1;
      end else begin
        for (int k = 0; k < int'(NrTargets); k++) begin
          if (head_id == IdWidth'(k)) begin
            instr_rvalid_o = tgt_rvalid_i[k];
            instr_rdata_o  = tgt_rdata_i[k];
            instr_err_o    = tgt_err_i[k];
          end
        end
      end
    end
    for (int k = 0; k < int'(NrTargets); k++) begin
      if (tgt_rvalid_i[k] && (empty || head_id != IdWidth'(k))) stray = 1'b1;
    end
  end

  assign pop = instr_rvalid_o;

  // Next-state for the ID queue, its pointers/count and the sticky error.
  always_comb begin
    fifo_d      = fifo_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    cnt_d       = cnt_q;
    proto_err_d = proto_err_q | stray;
    if (push) begin
      fifo_d[wptr_q] = dec_id;
      wptr_d         = ptr_inc(wptr_q);
    end
    if (pop) rptr_d = ptr_inc(rptr_q);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers; reset empties the queue and clears the error flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fifo_q      <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      cnt_q       <= '0;
      proto_err_q <= 1'b0;
    end else begin
      fifo_q      <= fifo_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      cnt_q       <= cnt_d;
      proto_err_q <= proto_err_d;
    end
  end

endmodule

// File: tb/tb_ifetch_router.sv
// Testbench for ifetch_router: decode vector table, directed multi-cycle sequences, randomized run vs. queue model.
module tb_ifetch_router;
  localparam int NT = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MO = 2;
  localparam logic [31:0] A0 = 32'h0010_0080;
  localparam logic [31:0] A1 = 32'h0004_1000;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 req;
  logic [AW-1:0]        addr;
  logic                 gnt;
  logic                 rvalid;
  logic [DW-1:0]        rdata;
  logic                 err;
  logic [NT-1:0][AW-1:0] base, mask;
  logic [NT-1:0]        tgt_req;
  logic [AW-1:0]        tgt_addr;
  logic [NT-1:0]        tgt_gnt;
  logic [NT-1:0]        tgt_rvalid;
  logic [NT-1:0][DW-1:0] tgt_rdata;
  logic [NT-1:0]        tgt_err;
  logic                 proto_err;

  ifetch_router #(.NrTargets(NT), .AddrWidth(AW), .DataWidth(DW), .MaxOutstanding(MO)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .instr_req_i(req), .instr_addr_i(addr), .instr_gnt_o(gnt),
    .instr_rvalid_o(rvalid), .instr_rdata_o(rdata), .instr_err_o(err),
    .cfg_addr_base_i(base), .cfg_addr_mask_i(mask),
    .tgt_req_o(tgt_req), .tgt_addr_o(tgt_addr), .tgt_gnt_i(tgt_gnt),
    .tgt_rvalid_i(tgt_rvalid), .tgt_rdata_i(tgt_rdata), .tgt_err_i(tgt_err),
    .proto_err_o(proto_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_rsp(input string name, input logic v, input logic e, input logic [31:0] d);
    chk({name, ".rvalid"}, rvalid, v);
    chk({name, ".err"}, err, e);
    chk({name, ".rdata"}, rdata, d);
  endtask

  // Inputs change at the falling edge; outputs are sampled 1ns later.
  task automatic drive(input logic r, input logic [31:0] a, input logic [1:0] g, input logic [1:0] rv);
    @(negedge clk);
    req = r; addr = a; tgt_gnt = g; tgt_rvalid = rv;
    #1;
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst_n = 1'b0; req = 1'b0; tgt_rvalid = '0; tgt_gnt = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Reference decode straight from the address-window rule.
  function automatic int decode(input logic [31:0] a);
    for (int k = 0; k < NT; k++) if ((a & mask[k]) == base[k]) return k;
    return NT;
  endfunction

  typedef struct {
    logic [31:0] a;
    logic        r;
    logic [1:0]  g;
    logic        ovl;
    logic [1:0]  exp_req;
    logic        exp_gnt;
  } vec_t;

  vec_t vecs[12];
  int   q[$];

  initial begin
    vecs[0]  = '{32'h0010_0080, 1'b1, 2'b01, 1'b0, 2'b01, 1'b1};
    vecs[1]  = '{32'h0010_0080, 1'b1, 2'b10, 1'b0, 2'b01, 1'b0};
    vecs[2]  = '{32'h0004_1234, 1'b1, 2'b10, 1'b0, 2'b10, 1'b1};
    vecs[3]  = '{32'h0004_1234, 1'b1, 2'b01, 1'b0, 2'b10, 1'b0};
    vecs[4]  = '{32'h0000_0000, 1'b1, 2'b00, 1'b0, 2'b00, 1'b1};
    vecs[5]  = '{32'h0000_0000, 1'b0, 2'b11, 1'b0, 2'b00, 1'b0};
    vecs[6]  = '{32'h001F_FFFF, 1'b1, 2'b01, 1'b0, 2'b01, 1'b1};
    vecs[7]  = '{32'h0020_0000, 1'b1, 2'b00, 1'b0, 2'b00, 1'b1};
    vecs[8]  = '{32'h0004_FFFF, 1'b1, 2'b11, 1'b0, 2'b10, 1'b1};
    vecs[9]  = '{32'h0005_0000, 1'b1, 2'b00, 1'b0, 2'b00, 1'b1};
    vecs[10] = '{32'h0010_0080, 1'b1, 2'b10, 1'b1, 2'b01, 1'b0};
    vecs[11] = '{32'h0010_0080, 1'b0, 2'b01, 1'b0, 2'b00, 1'b1};

    base[0] = 32'h0010_0000; mask[0] = ~32'h000F_FFFF;
    base[1] = 32'h0004_0000; mask[1] = ~32'h0000_FFFF;
    rst_n = 1'b0; req = 1'b0; addr = '0; tgt_gnt = '0; tgt_rvalid = '0;
    tgt_rdata = '0; tgt_err = '0;

    // Reset state
    #12;
    chk_rsp("reset", 1'b0, 1'b0, 32'h0);
    chk("reset.proto", proto_err, 1'b0);
    chk("reset.tgt_req", tgt_req, 2'b00);
    chk("reset.gnt", gnt, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Decode/grant table; req drops before the rising edge so nothing is queued.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (vecs[i].ovl) begin base[1] = base[0]; mask[1] = mask[0]; end
      req = vecs[i].r; addr = vecs[i].a; tgt_gnt = vecs[i].g;
      #1;
      chk($sformatf("vec%0d.tgt_req", i), tgt_req, vecs[i].exp_req);
      chk($sformatf("vec%0d.gnt", i), gnt, vecs[i].exp_gnt);
      chk($sformatf("vec%0d.tgt_addr", i), tgt_addr, vecs[i].a);
      chk($sformatf("vec%0d.rvalid", i), rvalid, 1'b0);
      #1;
      req = 1'b0;
      base[1] = 32'h0004_0000; mask[1] = ~32'h0000_FFFF;
    end

    // Mapped fetch to target 0, answered next cycle
    tgt_rdata[0] = 32'hCAFE_0001;
    drive(1'b1, A0, 2'b01, 2'b00);
    chk("t0.tgt_req", tgt_req, 2'b01);
    chk("t0.gnt", gnt, 1'b1);
    drive(1'b0, 32'h0, 2'b00, 2'b01);
    chk_rsp("t0.rsp", 1'b1, 1'b0, 32'hCAFE_0001);
    drive(1'b0, 32'h0, 2'b00, 2'b00);
    chk_rsp("t0.idle", 1'b0, 1'b0, 32'h0);

    // Unmapped fetch: local grant, error response one cycle later
    drive(1'b1, 32'h0, 2'b11, 2'b00);
    chk("unm.gnt", gnt, 1'b1);
    chk("unm.tgt_req", tgt_req, 2'b00);
    drive(1'b0, 32'h0, 2'b00, 2'b00);
    chk_rsp("unm.rsp", 1'b1, 1'b1, 32'h0);
    drive(1'b0, 32'h0, 2'b00, 2'b00);
    chk_rsp("unm.idle", 1'b0, 1'b0, 32'h0);

    // Full queue blocks the third fetch until a response drains one entry
    drive(1'b1, A0, 2'b01, 2'b00);
    chk("full.g1", gnt, 1'b1);
    drive(1'b1, A0, 2'b01, 2'b00);
    chk("full.g2", gnt, 1'b1);
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, A0, 2'b01, 2'b00);
      chk("full.blk_gnt", gnt, 1'b0);
      chk("full.blk_req", tgt_req, 2'b00);
      chk("full.blk_rv", rvalid, 1'b0);
    end
    tgt_rdata[0] = 32'h0000_00A1;
    drive(1'b1, A0, 2'b01, 2'b01);
    chk("full.rsp1_gnt", gnt, 1'b0);
    chk_rsp("full.rsp1", 1'b1, 1'b0, 32'hA1);
    tgt_rdata[0] = 32'h0000_00A2;
    drive(1'b1, A0, 2'b01, 2'b00);
    chk("full.reopen_gnt", gnt, 1'b1);
    chk("full.reopen_req", tgt_req, 2'b01);
    drive(1'b0, 32'h0, 2'b00, 2'b01);
    chk_rsp("full.rsp2", 1'b1, 1'b0, 32'hA2);
    tgt_rdata[0] = 32'h0000_00A3;
    drive(1'b0, 32'h0, 2'b00, 2'b01);
    chk_rsp("full.rsp3", 1'b1, 1'b0, 32'hA3);
    drive(1'b0, 32'h0, 2'b00, 2'b00);
    chk_rsp("full.idle", 1'b0, 1'b0, 32'h0);
    chk("full.proto", proto_err, 1'b0);

    // Out-of-order target answer is dropped and flagged
    tgt_rdata[0] = 32'hD000_0000; tgt_rdata[1] = 32'hD111_1111;
    drive(1'b1, A0, 2'b11, 2'b00);
    chk("ooo.req0", tgt_req, 2'b01);
    drive(1'b1, A1, 2'b11, 2'b00);
    chk("ooo.req1", tgt_req, 2'b10);
    chk("ooo.gnt1", gnt, 1'b1);
    drive(1'b0, 32'h0, 2'b00, 2'b10);
    chk("ooo.early_rv", rvalid, 1'b0);
    drive(1'b0, 32'h0, 2'b00, 2'b00);
    chk("ooo.proto", proto_err, 1'b1);
    chk("ooo.wait_rv", rvalid, 1'b0);
    drive(1'b0, 32'h0, 2'b00, 2'b01);
    chk_rsp("ooo.rsp0", 1'b1, 1'b0, 32'hD000_0000);
    drive(1'b0, 32'h0, 2'b00, 2'b10);
    chk_rsp("ooo.rsp1", 1'b1, 1'b0, 32'hD111_1111);
    drive(1'b0, 32'h0, 2'b00, 2'b00);
    chk("ooo.proto_sticky", proto_err, 1'b1);

    // Reset with fetches in flight; late answer is a protocol error
    reset_pulse();
    #1;
    chk("rst.proto_clr", proto_err, 1'b0);
    drive(1'b1, A0, 2'b01, 2'b00);
    drive(1'b1, A0, 2'b01, 2'b00);
    @(negedge clk);
    rst_n = 1'b0; req = 1'b1; addr = A0; tgt_gnt = 2'b01; tgt_rvalid = 2'b01;
    #1;
    chk_rsp("rst.in", 1'b0, 1'b0, 32'h0);
    chk("rst.in_proto", proto_err, 1'b0);
    chk("rst.in_gnt", gnt, 1'b1);
    chk("rst.in_req", tgt_req, 2'b01);
    @(negedge clk);
    rst_n = 1'b1; req = 1'b0; tgt_rvalid = 2'b00;
    drive(1'b0, 32'h0, 2'b00, 2'b01);
    chk("rst.late_rv", rvalid, 1'b0);
    drive(1'b0, 32'h0, 2'b00, 2'b00);
    chk("rst.late_proto", proto_err, 1'b1);

    // Back-to-back fetches with single-cycle answers
    reset_pulse();
    drive(1'b1, A0, 2'b01, 2'b00);
    chk("b2b.first_gnt", gnt, 1'b1);
    for (int i = 1; i <= 5; i++) begin
      tgt_rdata[0] = 32'h500 + 32'(i);
      drive(1'b1, A0, 2'b01, 2'b01);
      chk($sformatf("b2b%0d.gnt", i), gnt, 1'b1);
      chk_rsp($sformatf("b2b%0d", i), 1'b1, 1'b0, 32'h500 + 32'(i));
    end
    tgt_rdata[0] = 32'h506;
    drive(1'b0, 32'h0, 2'b00, 2'b01);
    chk_rsp("b2b.last", 1'b1, 1'b0, 32'h506);
    drive(1'b0, 32'h0, 2'b00, 2'b00);
    chk_rsp("b2b.idle", 1'b0, 1'b0, 32'h0);
    chk("b2b.proto", proto_err, 1'b0);

    // Randomized traffic against an in-order queue model
    reset_pulse();
    q.delete();
    for (int c = 0; c < 400; c++) begin
      int sel, id, h;
      logic [1:0] e_req;
      logic e_gnt, e_rv, e_err;
      logic [31:0] e_dat;
      @(negedge clk);
      sel = $urandom_range(0, 2);
      if (sel == 0)      addr = 32'h0010_0000 | ($urandom & 32'h000F_FFFF);
      else if (sel == 1) addr = 32'h0004_0000 | ($urandom & 32'h0000_FFFF);
      else               addr = 32'h8000_0000 | ($urandom & 32'h0000_FFFF);
      req          = 1'($urandom_range(0, 3) != 0);
      tgt_gnt      = 2'($urandom);
      tgt_rdata[0] = $urandom;
      tgt_rdata[1] = $urandom;
      tgt_err      = 2'($urandom);
      tgt_rvalid   = '0;
      if (q.size() > 0 && q[0] < NT && $urandom_range(0, 1) == 1) tgt_rvalid[q[0]] = 1'b1;
      #1;
      id = decode(addr);
      e_req = '0; e_gnt = 1'b0;
      if (q.size() < MO) begin
        if (id == NT) e_gnt = req;
        else begin e_req[id] = req; e_gnt = tgt_gnt[id]; end
      end
      e_rv = 1'b0; e_err = 1'b0; e_dat = '0;
      if (q.size() > 0) begin
        h = q[0];
        if (h == NT) begin e_rv = 1'b1; e_err = 1'b1; end
        else begin e_rv = tgt_rvalid[h]; e_err = tgt_err[h]; e_dat = tgt_rdata[h]; end
      end
      chk("rnd.tgt_req", tgt_req, e_req);
      chk("rnd.gnt", gnt, e_gnt);
      chk_rsp("rnd", e_rv, e_err, e_dat);
      if (e_rv) void'(q.pop_front());
      if (req && e_gnt) q.push_back(id);
    end
    @(negedge clk);
    req = 1'b0; tgt_rvalid = '0;
    #1;
    chk("rnd.proto", proto_err, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
